// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and main-memory signals of the memory arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) ();
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [LINE_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_ack;
  logic [LINE_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares main memory between I and D line controllers, D priority with I anti-starvation.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input logic         clock,
  input logic         reset,
  mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  localparam logic [1:0] IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2, RESP = 2'd3;
  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              grant_i, grant_d, busy;
  always_comb begin
    grant_i   = bus.i_req && (!bus.d_req || starve_q == LIM);
    grant_d   = bus.d_req && !grant_i;
    busy      = state_q == BUSY_I || state_q == BUSY_D;
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    starve_d  = starve_q;
    if (state_q == IDLE) begin
      if (grant_i || grant_d) begin
        state_d = grant_i ? BUSY_I : BUSY_D;
        owner_d = grant_d;
        we_d    = grant_d && bus.d_we;
        addr_d  = grant_i ? bus.i_addr : bus.d_addr;
        wdata_d = grant_d ? bus.d_wdata : '0;
      end
      // count D wins only while I is actually waiting
      starve_d = (grant_i || !bus.i_req) ? '0 :
                 (grant_d && starve_q != LIM) ? starve_q + SW'(1) : starve_q;
    end else if (busy && bus.mem_ready) begin
      state_d   = RESP;
      i_rdata_d = !owner_q ? bus.mem_rdata : i_rdata_q;
      d_rdata_d = (owner_q && !we_q) ? bus.mem_rdata : d_rdata_q;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      starve_q  <= starve_d;
    end
  end
  assign bus.mem_req   = busy;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_ack     = state_q == RESP && !owner_q;
  assign bus.d_ack     = state_q == RESP && owner_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of reset, I/D transactions, starvation order and abort-by-reset.
module tb_mem_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  mem_arbiter_if #(.ADDR_W(32), .LINE_W(128)) bus ();
  mem_arbiter #(.ADDR_W(32), .LINE_W(128), .STARVE_LIMIT(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clock = ~clock;
  localparam logic [127:0] R1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] RI = 128'hDEADBEEF_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] A5 = {16{8'hA5}};
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic txn(input bit exp_i, input int idx);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.mem_req && n < 8);
    chk($sformatf("grant_latency_%0d", idx), 128'(n), 128'd1);
    chk($sformatf("grant_owner_%0d", idx), 128'(bus.mem_addr), exp_i ? 128'h40 : 128'h300);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = {4{32'(idx)}};
    step();
    bus.mem_ready = 1'b0;
    chk($sformatf("starve_iack_%0d", idx), 128'(bus.i_ack), 128'(exp_i));
    chk($sformatf("starve_dack_%0d", idx), 128'(bus.d_ack), 128'(!exp_i));
    step();
  endtask
  initial begin
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b0;
    step();
    step();
    chk("rst_mem_req", 128'(bus.mem_req), 0);
    chk("rst_mem_we", 128'(bus.mem_we), 0);
    chk("rst_mem_addr", 128'(bus.mem_addr), 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_i_ack", 128'(bus.i_ack), 0);
    chk("rst_d_ack", 128'(bus.d_ack), 0);
    chk("rst_i_rdata", bus.i_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    reset = 1'b0;
    step();
    chk("first_grant_req", 128'(bus.mem_req), 1);
    chk("first_grant_addr", 128'(bus.mem_addr), 128'h200);
    chk("first_grant_we", 128'(bus.mem_we), 0);
    bus.mem_ready = 1'b1; bus.mem_rdata = R1;
    step();
    bus.mem_ready = 1'b0; bus.d_req = 1'b0;
    chk("dread_ack", 128'(bus.d_ack), 1);
    chk("dread_iack", 128'(bus.i_ack), 0);
    chk("dread_rdata", bus.d_rdata, R1);
    chk("dread_resp_memreq", 128'(bus.mem_req), 0);
    step();
    chk("idle_no_dack", 128'(bus.d_ack), 0);
    step();
    chk("iread_req", 128'(bus.mem_req), 1);
    chk("iread_addr", 128'(bus.mem_addr), 128'h40);
    chk("iread_we0", 128'(bus.mem_we), 0);
    step();
    step();
    chk("iread_wait_req", 128'(bus.mem_req), 1);
    chk("iread_wait_we", 128'(bus.mem_we), 0);
    chk("iread_wait_noack", 128'(bus.i_ack), 0);
    bus.mem_ready = 1'b1; bus.mem_rdata = RI;
    step();
    bus.mem_ready = 1'b0; bus.i_req = 1'b0;
    chk("iread_ack", 128'(bus.i_ack), 1);
    chk("iread_rdata", bus.i_rdata, RI);
    chk("iread_we_resp", 128'(bus.mem_we), 0);
    step();
    chk("iread_ack_pulse", 128'(bus.i_ack), 0);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = A5;
    step();
    chk("dwr_req", 128'(bus.mem_req), 1);
    chk("dwr_we", 128'(bus.mem_we), 1);
    chk("dwr_addr", 128'(bus.mem_addr), 128'h100);
    chk("dwr_wdata", bus.mem_wdata, A5);
    bus.mem_ready = 1'b1; bus.mem_rdata = 128'h1234;
    step();
    bus.mem_ready = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    chk("dwr_ack", 128'(bus.d_ack), 1);
    chk("dwr_rdata_kept", bus.d_rdata, R1);
    step();
    bus.mem_ready = 1'b1; bus.mem_rdata = {128{1'b1}};
    step();
    bus.mem_ready = 1'b0;
    chk("stray_memreq", 128'(bus.mem_req), 0);
    chk("stray_iack", 128'(bus.i_ack), 0);
    chk("stray_dack", 128'(bus.d_ack), 0);
    chk("stray_irdata", bus.i_rdata, RI);
    chk("stray_drdata", bus.d_rdata, R1);
    step();
    chk("stray_still_idle", 128'(bus.mem_req), 0);
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
    for (int k = 0; k < 10; k++) txn(k == 4 || k == 9, k);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    step();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h500; bus.d_wdata = A5;
    step();
    chk("abort_grant", 128'(bus.mem_req), 1);
    step();
    step();
    reset = 1'b1;
    step();
    chk("abort_memreq", 128'(bus.mem_req), 0);
    chk("abort_dack", 128'(bus.d_ack), 0);
    chk("abort_addr_cleared", 128'(bus.mem_addr), 0);
    reset = 1'b0;
    step();
    chk("regrant_req", 128'(bus.mem_req), 1);
    chk("regrant_addr", 128'(bus.mem_addr), 128'h500);
    chk("regrant_we", 128'(bus.mem_we), 1);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0; bus.d_req = 1'b0;
    chk("regrant_ack", 128'(bus.d_ack), 1);
    chk("regrant_drdata", bus.d_rdata, 0);
    step();
    chk("end_idle", 128'(bus.mem_req), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single main-memory port between the instruction-memory controller (line refills) and the data-memory controller (line refills and write-backs). It sits below both cache controllers and holds each requester stalled until its transaction is acknowledged. Arbitration is data-side priority with an anti-starvation counter that guarantees the fetch side a grant.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- LINE_W, 128, cache line width in bits
- STARVE_LIMIT, 4, consecutive D grants while I waits before I is forced ahead (≥1)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- i_req  in  1  instruction-side line read request, held until i_ack
- i_addr  in  ADDR_W  line address, stable while i_req
- i_ack  out  1  one-cycle pulse: transaction complete, i_rdata valid
- i_rdata  out  LINE_W  returned line, registered
- d_req  in  1  data-side request, held until d_ack
- d_we  in  1  1 = line write, 0 = line read; stable while d_req
- d_addr  in  ADDR_W  line address
- d_wdata  in  LINE_W  write line
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  LINE_W  returned line for reads, registered
- mem_req  out  1  memory transaction active
- mem_we  out  1  write when mem_req
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  LINE_W  memory write data
- mem_rdata  in  LINE_W  memory read data, valid with mem_ready
- mem_ready  in  1  one-cycle pulse: memory done

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: if no request, stay. If only one requests, grant it. If both: grant D unless starve_cnt == STARVE_LIMIT, then grant I.
- Grant latches owner, addr, we (0 for I), wdata into registers; next state BUSY_x.
- BUSY_x: mem_req=1 with latched fields; wait for mem_ready. On mem_ready capture mem_rdata into x_rdata (reads only; d_rdata unchanged on writes), go RESP.
- RESP: pulse x_ack for the owner, mem_req=0, return to IDLE. The requester drops req on the cycle after ack; the arbiter never samples req in RESP.
- starve_cnt (width clog2(STARVE_LIMIT+1)): increments on each D grant while i_req=1; clears on any I grant or when i_req=0 in IDLE; saturates at STARVE_LIMIT.
- Addresses pass through unmodified; line alignment is the requester's responsibility.
- Requester dropping req before ack is illegal; the arbiter completes the transaction and still pulses ack.
- mem_ready outside BUSY_x is ignored.

## Timing
- Reset: state IDLE, all outputs 0 (i_ack, d_ack, i_rdata, d_rdata, mem_req, mem_we, mem_addr, mem_wdata), starve_cnt 0, owner cleared.
- Reset mid-transaction abandons it: mem_req low at the edge after reset is asserted, no ack is issued, the latched request is discarded.
- Request sampled in IDLE at edge N → mem_req high from cycle N+1.
- mem_ready in cycle M → x_ack and x_rdata valid in cycle M+1 → IDLE at M+2, next grant is visible at M+3.
- Minimum occupancy with 1-cycle memory: 3 cycles per transaction (BUSY, RESP, IDLE).
- mem_req, mem_we, mem_addr and mem_wdata are registered and stable for the whole BUSY_x state.
- Acks are never asserted for both sides in the same cycle, and never in consecutive cycles for the same requester.

## Test plan
- Reset: hold reset with i_req=d_req=1 → all outputs 0, no mem_req. Release → D granted first, mem_req=1 with d_addr the following cycle.
- Single I read: i_addr=0x0000_0040, memory returns 0xDEADBEEF_..._0001 after 3 cycles → i_ack one cycle after mem_ready, i_rdata equal to the returned line, mem_we=0 throughout.
- D write: d_we=1, d_addr=0x100, d_wdata=0xA5...A5 → mem_we=1 with matching addr and wdata, d_ack pulse, d_rdata unchanged.
- Starvation: i_req and d_req held high continuously with STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D,D,D,I; starve_cnt clears after the I grant.
- Reset mid-BUSY_D: reset asserted two cycles after grant → mem_req=0 next edge, no d_ack; after release, the held d_req is regranted from IDLE.
- Stray mem_ready in IDLE with no request → no ack, no state change, rdata registers unchanged.
